// File: rtl/cell_fetch.sv
// cell_fetch: reads the 3x3 toroidal neighbourhood of a board cell, one bit per
// cycle from a 1-cycle-latency BRAM, and reports window, centre state and count.
module cell_fetch #(
  parameter int LOG_BOARD_SIZE = 3
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          req_in,
  input  logic [LOG_BOARD_SIZE-1:0]     x_in,
  input  logic [LOG_BOARD_SIZE-1:0]     y_in,
  output logic [2*LOG_BOARD_SIZE-1:0]   rd_addr_out,
  output logic                          rd_en_out,
  input  logic                          rd_data_in,
  output logic [8:0]                    window_out,
  output logic                          alive_out,
  output logic [3:0]                    count_out,
  output logic                          fetch_ready_out,
  output logic                          busy_out
);

  localparam int LB = LOG_BOARD_SIZE;
  localparam int AW = 2 * LOG_BOARD_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } state_t;

  // Address of neighbour k; wrap-around comes from natural LB-bit overflow.
  function automatic logic [AW-1:0] nb_addr(input logic [3:0] k,
                                            input logic [LB-1:0] x,
                                            input logic [LB-1:0] y);
    logic [1:0]    dy_i;
    logic [1:0]    dx_i;
    logic [LB-1:0] row;
    logic [LB-1:0] col;
    case (k)
      4'd0:    begin dy_i = 2'd0; dx_i = 2'd0; end
      4'd1:    begin dy_i = 2'd0; dx_i = 2'd1; end
      4'd2:    begin dy_i = 2'd0; dx_i = 2'd2; end
      4'd3:    begin dy_i = 2'd1; dx_i = 2'd0; end
      4'd4:    begin dy_i = 2'd1; dx_i = 2'd1; end
      4'd5:    begin dy_i = 2'd1; dx_i = 2'd2; end
      4'd6:    begin dy_i = 2'd2; dx_i = 2'd0; end
      4'd7:    begin dy_i = 2'd2; dx_i = 2'd1; end
      4'd8:    begin dy_i = 2'd2; dx_i = 2'd2; end
      default: begin dy_i = 2'd1; dx_i = 2'd1; end
    endcase
    row = y + LB'(dy_i) - LB'(1'b1);
    col = x + LB'(dx_i) - LB'(1'b1);
    return {row, col};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  state_t         state_r;
  logic [3:0]     k_r;
  logic [LB-1:0]  x_r;
  logic [LB-1:0]  y_r;
  logic [7:0]     cap_r;
  logic [AW-1:0]  rd_addr_r;
  logic           rd_en_r;
  logic [8:0]     window_r;
  logic           alive_r;
  logic [3:0]     count_r;
  logic           ready_r;
  logic           busy_r;
  logic [8:0]     window_next_s;
  logic [3:0]     count_next_s;

  // Complete window once the last bit returns, and its neighbour count.
  always_comb begin
    window_next_s = {rd_data_in, cap_r};
    count_next_s  = popcount8({window_next_s[8:5], window_next_s[3:0]});
  end

  // Fetch sequencer: issues nine reads, shifts returns in, publishes in READY.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r   <= IDLE;
      k_r       <= 4'd0;
      x_r       <= '0;
      y_r       <= '0;
      cap_r     <= 8'd0;
      rd_addr_r <= '0;
      rd_en_r   <= 1'b0;
      window_r  <= 9'd0;
      alive_r   <= 1'b0;
      count_r   <= 4'd0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_in) begin
            x_r       <= x_in;
            y_r       <= y_in;
            cap_r     <= 8'd0;
            k_r       <= 4'd0;
            rd_addr_r <= nb_addr(4'd0, x_in, y_in);
            rd_en_r   <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ISSUE;
          end else begin
            rd_en_r   <= 1'b0;
          end
        end
        ISSUE: begin
          // Data for index k-1 is on the bus while index k is being driven.
          if (k_r != 4'd0) begin
            cap_r <= {rd_data_in, cap_r[7:1]};
          end else begin
            cap_r <= cap_r;
          end
          if (k_r == 4'd8) begin
            rd_en_r <= 1'b0;
            state_r <= DRAIN;
          end else begin
            k_r       <= k_r + 4'd1;
            rd_addr_r <= nb_addr(k_r + 4'd1, x_r, y_r);
          end
        end
        DRAIN: begin
          window_r <= window_next_s;
          alive_r  <= window_next_s[4];
          count_r  <= count_next_s;
          ready_r  <= 1'b1;
          rd_en_r  <= 1'b0;
          state_r  <= READY;
        end
        READY: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          rd_en_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr_out     = rd_addr_r;
  assign rd_en_out       = rd_en_r;
  assign window_out      = window_r;
  assign alive_out       = alive_r;
  assign count_out       = count_r;
  assign fetch_ready_out = ready_r;
  assign busy_out        = busy_r;

endmodule
